// File: rtl/key_ram_arbiter.sv
// key_ram_arbiter
//   Shares one single-port RAM between two clients: the keypad (writes one
//   key code per key_flag into a DEPTH-entry ring) and a periodic playback
//   tick (reads the oldest entry and presents it on disp_data).
//
// Ports
//   sys_clk, sys_rst_n    clock (rising edge) / asynchronous active-low reset
//   key_flag, key_data    one-cycle key strobe and its 4-bit code
//   clr                   synchronous flush of ring, flags, tick and FSM
//   ram_addr/ram_wdata    shared RAM address / write word ({key,key})
//   ram_we, ram_re        RAM strobes; ram_rdata is valid the cycle after ram_re
//   disp_data/disp_valid  last played word / one-cycle "new word" pulse
//   empty, full, level    ring status (level counts 0..DEPTH)
//   ovf                   sticky: a key was dropped (busy or ring full)
//   dbg_state             FSM state: 0 IDLE, 1 WRITE, 2 READ, 3 READ_WAIT
//
// Handshakes: key_flag is a push-only strobe with no ready; a strobe that
// finds the one-deep pending slot occupied is dropped and flagged in ovf.
// disp_valid is a push-only strobe with no ready: disp_data is new in the
// single cycle disp_valid is high and is held until the next playback.
module key_ram_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int TICK_CNT = 25_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_flag,
  input  logic [3:0]        key_data,
  input  logic              clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TICK_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT - 1);
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ      = 2'd2,
    S_READ_WAIT = 2'd3
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic              r_play_req;
  logic              r_wr_pend;
  logic [3:0]        r_key;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;

  logic w_full;
  logic w_empty;
  logic w_tick_wrap;
  logic w_grant_wr;

  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_tick_wrap = (r_tick == TICK_LAST);
  // Write wins when it is alone, or when both wait and read went last.
  assign w_grant_wr  = r_wr_pend && (!r_play_req || (r_last_grant == GRANT_RD));

  // Strobes come straight from the state register, so they can never overlap
  // and vanish the instant reset lands.
  assign ram_we     = (r_state == S_WRITE) && !w_full;
  assign ram_re     = (r_state == S_READ);
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign empty      = w_empty;
  assign full       = w_full;
  assign level      = r_level;
  assign ovf        = r_ovf;
  assign dbg_state  = r_state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick <= '0;
    end else if (clr || w_tick_wrap) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_play_req   <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_key        <= '0;
      r_last_grant <= GRANT_RD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
    end else if (clr) begin
      // Flush aborts any in-flight read: disp_valid is simply not raised.
      r_state      <= S_IDLE;
      r_play_req   <= 1'b0;
      r_wr_pend    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp_valid <= 1'b0;

      if (key_flag) begin
        if (r_wr_pend) begin
          r_ovf <= 1'b1;
        end else begin
          r_wr_pend <= 1'b1;
          r_key     <= key_data;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state      <= S_WRITE;
            r_last_grant <= GRANT_WR;
            r_ram_addr   <= r_wr_ptr;
            r_ram_wdata  <= DATA_W'({r_key, r_key});
          end else if (r_play_req) begin
            r_last_grant <= GRANT_RD;
            if (w_empty) begin
              // Nothing to play: retire the request without touching RAM.
              r_play_req <= 1'b0;
            end else begin
              r_state    <= S_READ;
              r_ram_addr <= r_rd_ptr;
            end
          end
        end
        S_WRITE: begin
          if (!w_full) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_level  <= r_level + 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
          r_wr_pend <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_READ: begin
          r_play_req <= 1'b0;
          r_state    <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          r_disp_data  <= ram_rdata;
          r_disp_valid <= 1'b1;
          r_rd_ptr     <= r_rd_ptr + 1'b1;
          r_level      <= r_level - 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A wrap in the same cycle as a service clear must survive.
      if (w_tick_wrap) begin
        r_play_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_ram_arbiter.sv
module tb_key_ram_arbiter;

  localparam int F_AW    = 3;
  localparam int F_DEPTH = 8;
  localparam int S_AW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // fast instance: TICK_CNT=4, 8-entry ring
  logic            f_key_flag = 1'b0;
  logic [3:0]      f_key_data = '0;
  logic            f_clr = 1'b0;
  logic [F_AW-1:0] f_ram_addr;
  logic [7:0]      f_ram_wdata;
  logic            f_ram_we, f_ram_re;
  logic [7:0]      f_ram_rdata;
  logic [7:0]      f_disp_data;
  logic            f_disp_valid, f_empty, f_full, f_ovf;
  logic [F_AW:0]   f_level;
  logic [1:0]      f_dbg;

  // slow instance: playback effectively off, 4-entry ring
  logic            s_key_flag = 1'b0;
  logic [3:0]      s_key_data = '0;
  logic            s_clr = 1'b0;
  logic [S_AW-1:0] s_ram_addr;
  logic [7:0]      s_ram_wdata;
  logic            s_ram_we, s_ram_re;
  logic [7:0]      s_ram_rdata;
  logic [7:0]      s_disp_data;
  logic            s_disp_valid, s_empty, s_full, s_ovf;
  logic [S_AW:0]   s_level;
  logic [1:0]      s_dbg;

  logic [7:0] f_mem [F_DEPTH];
  logic [7:0] s_mem [4];

  int checks = 0;
  int errors = 0;

  // scoreboard state for the fast instance
  logic [7:0] exp_q[$];   // keys sent, awaiting their RAM write
  logic [7:0] sq[$];      // words stored in the ring (model)
  logic [7:0] pq[$];      // words read, awaiting display
  bit         ev_q[$];    // 1 = write event, 0 = read event
  int         wr_idx, rd_idx, n_disp, re_cnt;
  bit         mon_en = 1'b0;
  bit         ev_en = 1'b0;
  bit         re_d1, re_d2;
  logic [7:0] mon_w;

  typedef struct {
    logic [3:0] key;
    logic       exp_we;
    logic [1:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [2:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  key_ram_arbiter #(.ADDR_W(F_AW), .DATA_W(8), .TICK_CNT(4)) u_fast (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_flag(f_key_flag), .key_data(f_key_data),
    .clr(f_clr), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_we(f_ram_we),
    .ram_re(f_ram_re), .ram_rdata(f_ram_rdata), .disp_data(f_disp_data),
    .disp_valid(f_disp_valid), .empty(f_empty), .full(f_full), .level(f_level),
    .ovf(f_ovf), .dbg_state(f_dbg)
  );

  key_ram_arbiter #(.ADDR_W(S_AW), .DATA_W(8), .TICK_CNT(4000)) u_slow (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_flag(s_key_flag), .key_data(s_key_data),
    .clr(s_clr), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we),
    .ram_re(s_ram_re), .ram_rdata(s_ram_rdata), .disp_data(s_disp_data),
    .disp_valid(s_disp_valid), .empty(s_empty), .full(s_full), .level(s_level),
    .ovf(s_ovf), .dbg_state(s_dbg)
  );

  // single-port RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (f_ram_we) f_mem[f_ram_addr] <= f_ram_wdata;
    if (f_ram_re) f_ram_rdata <= f_mem[f_ram_addr];
    if (s_ram_we) s_mem[s_ram_addr] <= s_ram_wdata;
    if (s_ram_re) s_ram_rdata <= s_mem[s_ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one #1 after the first edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    mon_en = 1'b0;
    ev_en = 1'b0;
    f_key_flag = 1'b0; f_clr = 1'b0; f_key_data = '0;
    s_key_flag = 1'b0; s_clr = 1'b0; s_key_data = '0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_fast(input logic [3:0] k, input int gap);
    step();
    f_key_flag = 1'b1;
    f_key_data = k;
    exp_q.push_back({k, k});
    step();
    f_key_flag = 1'b0;
    repeat (gap - 2) step();
  endtask

  // Ring model for the fast instance: keys are written in send order, read
  // in write order, displayed in read order, display two cycles after read.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); sq.delete(); pq.delete(); ev_q.delete();
      wr_idx = 0; rd_idx = 0; n_disp = 0; re_cnt = 0;
      re_d1 = 1'b0; re_d2 = 1'b0;
    end else if (mon_en) begin
      chk("we_re_exclusive", {31'b0, f_ram_we & f_ram_re}, 32'd0);
      if (f_ram_re) re_cnt++;
      if (ev_en && f_ram_we) ev_q.push_back(1'b1);
      if (ev_en && f_ram_re) ev_q.push_back(1'b0);
      if (f_ram_we) begin
        if (exp_q.size() == 0) unexpected("spurious_write");
        else begin
          mon_w = exp_q.pop_front();
          chk("wr_data", f_ram_wdata, mon_w);
          chk("wr_addr", f_ram_addr, wr_idx % F_DEPTH);
          sq.push_back(mon_w);
          wr_idx++;
        end
      end
      if (f_ram_re) begin
        if (sq.size() == 0) unexpected("spurious_read");
        else begin
          chk("rd_addr", f_ram_addr, rd_idx % F_DEPTH);
          pq.push_back(sq.pop_front());
          rd_idx++;
        end
      end
      if (f_disp_valid) begin
        chk("disp_2_after_re", re_d2, 1);
        if (pq.size() == 0) unexpected("spurious_disp");
        else begin
          mon_w = pq.pop_front();
          chk("disp_data", f_disp_data, mon_w);
          n_disp++;
        end
      end
      re_d2 = re_d1;
      re_d1 = f_ram_re;
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int r0;

    // ---------------- reset values
    do_reset();
    chk("rst_we", s_ram_we, 0);
    chk("rst_re", s_ram_re, 0);
    chk("rst_disp_data", s_disp_data, 0);
    chk("rst_disp_valid", s_disp_valid, 0);
    chk("rst_level", s_level, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_state", s_dbg, 0);
    chk("rst_fast_empty", f_empty, 1);

    // ---------------- table: fill the 4-entry ring, then overflow
    vecs[0] = '{4'h5, 1'b1, 2'd0, 8'h55, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{4'hA, 1'b1, 2'd1, 8'hAA, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{4'h3, 1'b1, 2'd2, 8'h33, 3'd3, 1'b0, 1'b0};
    vecs[3] = '{4'hF, 1'b1, 2'd3, 8'hFF, 3'd4, 1'b1, 1'b0};
    vecs[4] = '{4'h7, 1'b0, 2'd0, 8'h00, 3'd4, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step();
      s_key_flag = 1'b1;               // cycle 0
      s_key_data = vecs[i].key;
      step();
      s_key_flag = 1'b0;               // cycle 1
      step();                          // cycle 2: write strobe
      chk($sformatf("tbl%0d_we", i), s_ram_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("tbl%0d_addr", i), s_ram_addr, vecs[i].exp_addr);
        chk($sformatf("tbl%0d_wdata", i), s_ram_wdata, vecs[i].exp_wdata);
      end
      step();                          // cycle 3: status updated
      chk($sformatf("tbl%0d_level", i), s_level, vecs[i].exp_level);
      chk($sformatf("tbl%0d_full", i), s_full, vecs[i].exp_full);
      chk($sformatf("tbl%0d_empty", i), s_empty, vecs[i].exp_level == 0);
      chk($sformatf("tbl%0d_ovf", i), s_ovf, vecs[i].exp_ovf);
    end

    // ---------------- reset in the middle of a write
    do_reset();
    step();
    s_key_flag = 1'b1;
    s_key_data = 4'hA;
    step();
    s_key_flag = 1'b0;
    step();
    chk("midrst_we_before", s_ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", s_ram_we, 0);
    chk("midrst_re", s_ram_re, 0);
    chk("midrst_wdata", s_ram_wdata, 0);
    chk("midrst_level", s_level, 0);
    chk("midrst_empty", s_empty, 1);
    chk("midrst_full", s_full, 0);
    chk("midrst_ovf", s_ovf, 0);
    chk("midrst_disp", {s_disp_valid, s_disp_data}, 0);

    // ---------------- key and tick wrap together, then alternation
    do_reset();
    mon_en = 1'b1;
    ev_en = 1'b1;
    repeat (3) step();
    f_key_flag = 1'b1; f_key_data = 4'h1; exp_q.push_back(8'h11);
    step();
    f_key_flag = 1'b0;
    step();
    chk("arb_first_write", {f_ram_we, f_ram_re}, 2'b10);
    repeat (2) step();
    chk("arb_then_read", {f_ram_we, f_ram_re}, 2'b01);
    f_key_flag = 1'b1; f_key_data = 4'h2; exp_q.push_back(8'h22);
    step();
    f_key_flag = 1'b0;
    step();
    chk("arb_disp_valid", f_disp_valid, 1);
    repeat (2) step();
    f_key_flag = 1'b1; f_key_data = 4'h3; exp_q.push_back(8'h33);
    step();
    f_key_flag = 1'b0;
    repeat (25) step();
    ev_en = 1'b0;
    chk("arb_event_count", ev_q.size(), 6);
    for (int i = 0; i < ev_q.size(); i++)
      chk($sformatf("arb_alternate%0d", i), ev_q[i], (i % 2) == 0);
    chk("arb_played", n_disp, 3);

    // ---------------- playback of 1,2,3 then random traffic
    do_reset();
    mon_en = 1'b1;
    send_fast(4'h1, 6);
    send_fast(4'h2, 6);
    send_fast(4'h3, 6);
    repeat (30) step();
    chk("play3_count", n_disp, 3);
    chk("play3_drained", exp_q.size() + sq.size() + pq.size(), 0);
    chk("play3_empty", f_empty, 1);
    r0 = re_cnt;
    repeat (20) step();
    chk("play3_no_more_reads", re_cnt, r0);
    for (int n = 0; n < 40; n++)
      send_fast(4'($urandom_range(0, 15)), $urandom_range(6, 12));
    repeat (40) step();
    chk("rand_count", n_disp, 43);
    chk("rand_drained", exp_q.size() + sq.size() + pq.size(), 0);
    chk("rand_level", f_level, 0);
    chk("rand_empty", f_empty, 1);
    chk("rand_full", f_full, 0);
    chk("rand_ovf", f_ovf, 0);

    // ---------------- clr during READ_WAIT
    do_reset();
    repeat (3) step();
    f_key_flag = 1'b1; f_key_data = 4'h9;   // captured with the tick wrap
    step();
    f_key_data = 4'h6;                      // arrives while pending: dropped
    step();
    f_key_flag = 1'b0;
    chk("clr_pre_we", {f_ram_we, f_ram_addr, f_ram_wdata}, {1'b1, 3'd0, 8'h99});
    step();
    chk("clr_pre_ovf", f_ovf, 1);
    step();
    chk("clr_pre_re", f_ram_re, 1);
    step();
    chk("clr_in_read_wait", f_dbg, 3);
    f_clr = 1'b1;
    step();
    f_clr = 1'b0;
    chk("clr_no_disp", f_disp_valid, 0);
    chk("clr_level", f_level, 0);
    chk("clr_empty", f_empty, 1);
    chk("clr_ovf", f_ovf, 0);
    step();
    chk("clr_no_disp_late", f_disp_valid, 0);
    f_key_flag = 1'b1; f_key_data = 4'hC;
    step();
    f_key_flag = 1'b0;
    step();
    chk("clr_next_write", {f_ram_we, f_ram_addr, f_ram_wdata}, {1'b1, 3'd0, 8'hCC});
    repeat (2) step();                      // tick restarted at clr: wrap read
    chk("clr_read_latency", {f_ram_re, f_ram_addr}, {1'b1, 3'd0});
    repeat (2) step();
    chk("clr_disp_latency", {f_disp_valid, f_disp_data}, {1'b1, 8'hCC});
    step();
    chk("clr_disp_hold", {f_disp_valid, f_disp_data}, {1'b0, 8'hCC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_ram_arbiter.md
KEY_RAM_ARBITER -- requirements
Module: key_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning RAM address width; ring depth DEPTH = 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM word width (2 x 4-bit key code).
REQ-003 SHALL have parameter TICK_CNT, default 25_000_000, meaning playback period in sys_clk cycles (0.5 s at 50 MHz).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port key_flag, input, 1 bit: single-cycle write request from the keypad edge detector.
REQ-007 SHALL have port key_data, input, 4 bits: key code, sampled in the key_flag cycle.
REQ-008 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-009 SHALL have port ram_addr, output, ADDR_W bits: shared single-port RAM address.
REQ-010 SHALL have port ram_wdata, output, DATA_W bits: RAM write data.
REQ-011 SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-012 SHALL have port ram_re, output, 1 bit: RAM read enable.
REQ-013 SHALL have port ram_rdata, input, DATA_W bits: RAM read data, valid the cycle after ram_re.
REQ-014 SHALL have port disp_data, output, DATA_W bits: last word played back to the display.
REQ-015 SHALL have port disp_valid, output, 1 bit: one-cycle pulse marking new disp_data.
REQ-016 SHALL have ports empty and full, outputs, 1 bit each: ring status.
REQ-017 SHALL have port level, output, ADDR_W+1 bits: stored entries, 0..DEPTH.
REQ-018 SHALL have port ovf, output, 1 bit: sticky flag for a dropped key.

Function
REQ-019 SHALL latch key_flag/key_data into one-deep wr_pend; a key_flag while wr_pend is set SHALL set ovf and drop the new key.
REQ-020 SHALL run tick counter 0..TICK_CNT-1, wrapping; the wrap cycle SHALL set play_req, held until serviced.
REQ-021 SHALL implement FSM IDLE, WRITE, READ, READ_WAIT; reset state IDLE.
REQ-022 In IDLE with both requests pending, SHALL grant the requester not granted last (last_grant bit, reset = read, so write wins first); with one pending, grant it.
REQ-023 Read grant with empty=1 SHALL clear play_req and stay IDLE with no RAM access.
REQ-024 In WRITE, if not full: ram_we=1, ram_addr=wr_ptr, ram_wdata={key_data,key_data}, wr_ptr+1, level+1; if full: no ram_we, ovf set, key dropped; always clear wr_pend and return to IDLE.
REQ-025 In READ: ram_re=1, ram_addr=rd_ptr, clear play_req, go READ_WAIT.
REQ-026 In READ_WAIT: register ram_rdata into disp_data, pulse disp_valid next cycle, rd_ptr+1, level-1, go IDLE.
REQ-027 ram_we/ram_re SHALL be decoded from state register only, never both high; ram_addr/ram_wdata hold otherwise.
REQ-028 Latency: key_flag in cycle 0 with FSM idle -> ram_we in cycle 2; tick wrap in cycle 0 -> ram_re in cycle 2, disp_valid in cycle 4.
REQ-029 Pointers SHALL wrap modulo DEPTH; empty = (level==0), full = (level==DEPTH).
REQ-030 disp_data SHALL hold its value between reads.
REQ-031 clr SHALL override everything: pointers, level, wr_pend, play_req, ovf, tick counter to 0, state IDLE; an in-flight READ_WAIT SHALL be aborted with no disp_valid.

Reset
REQ-032 On sys_rst_n low all registers SHALL clear asynchronously: state IDLE, ram_we=ram_re=0, disp_data=0, disp_valid=0, level=0, empty=1, full=0, ovf=0, tick=0, last_grant=read.

Verification
REQ-033 Reset, key_flag with key_data=4'h5 -> ram_we cycle 2, ram_addr=0, ram_wdata=8'h55, level=1, empty=0.
REQ-034 Keys 1,2,3 stored, TICK_CNT=4 -> disp_data 8'h11, 8'h22, 8'h33 in order, each disp_valid 2 cycles after ram_re; then empty=1, no further ram_re.
REQ-035 DEPTH+1 keys, no playback -> full=1 at level=DEPTH, extra key gives no ram_we, ovf=1, level stays DEPTH.
REQ-036 key_flag and tick wrap same cycle, then repeated key_flag -> write granted first, read next, grants alternate; no lost play_req.
REQ-037 clr asserted while in READ_WAIT -> no disp_valid, level=0, empty=1, ovf=0, next write at ram_addr=0.
REQ-038 sys_rst_n low mid-WRITE -> ram_we drops immediately, all outputs at REQ-032 values.
